// File: rtl/run_det_pkg.sv
// Shared types and the symbol qualifier for run_length_detector.
package run_det_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_ANY   = 2'b00,
        MODE_ONES  = 2'b01,
        MODE_ZEROS = 2'b10,
        MODE_BOTH  = 2'b11
    } mode_e;

    // The caller reduces the symbol to all-ones/all-zeros flags so that this
    // function does not depend on the symbol width.
    function automatic logic qual(input logic sym_ones, input logic sym_zeros,
                                  input mode_e sel);
        logic q;
        q = 1'b0;
        case (sel)
            MODE_ANY:   q = 1'b1;
            MODE_ONES:  q = sym_ones;
            MODE_ZEROS: q = sym_zeros;
            MODE_BOTH:  q = sym_ones | sym_zeros;
            default:    q = 1'b0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and load-to-one.
// Priority: clr, then load1, then inc. Holds at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned MAX   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= WIDTH'(1);
        end else if (inc && (count != WIDTH'(MAX))) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_length_detector.sv
// run_length_detector: asserts match while the most recent accepted symbol has
// repeated at least RUN_LEN consecutive accepted cycles and qualifies under mode.
// Optional feature: define RLD_MATCH_CNT_EN to add the 16-bit match_cnt output
// counting rising edges of match.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter  int unsigned DATA_W  = 1,
    parameter  int unsigned RUN_LEN = 3,
    localparam int unsigned CNT_W   = $clog2(RUN_LEN + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        mode,
    output logic              match,
    output logic [CNT_W-1:0]  run_len,
    output logic [DATA_W-1:0] last_sym
`ifdef RLD_MATCH_CNT_EN
    ,
    output logic [15:0]       match_cnt
`endif
);

    state_e state_q;
    state_e state_d;
    logic   run_load;
    logic   run_inc;
    logic   same_sym;

    assign same_sym = (in_data == last_sym);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and run-counter controls; clear overrides any accepted symbol
    always_comb begin
        state_d  = state_q;
        run_load = 1'b0;
        run_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    run_load = 1'b1;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (same_sym) begin
                        run_inc = 1'b1;
                    end else begin
                        run_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d  = IDLE;
            run_load = 1'b0;
            run_inc  = 1'b0;
        end
    end

    // Most recently accepted symbol
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_sym <= '0;
        end else if (clear) begin
            last_sym <= '0;
        end else if (in_valid) begin
            last_sym <= in_data;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W),
        .MAX   (RUN_LEN)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .load1 (run_load),
        .inc   (run_inc),
        .count (run_len)
    );

    // Moore decode; mode is applied live so a mode change shows up without an edge
    always_comb begin
        match = (state_q == RUN) && (run_len == CNT_W'(RUN_LEN)) &&
                qual(&last_sym, ~|last_sym, mode_e'(mode));
    end

`ifdef RLD_MATCH_CNT_EN
    logic match_q;

    // Previous match, for rising-edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_q <= 1'b0;
        end else if (clear) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    sat_counter #(
        .WIDTH (16),
        .MAX   (65535)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .load1 (1'b0),
        .inc   (match && !match_q),
        .count (match_cnt)
    );
`endif

endmodule
